cpc_io_wr_capture: RTL and testbench

- Upstream stage for the RAM bank configuration register.
- Samples the raw Z80 bus on the board clock and qualifies I/O write cycles, rejecting interrupt-acknowledge cycles and glitches.
- Decodes a RAM-config write (A15=0, D[7:6]=CFG_SEL) and issues a single-cycle strobe with D[5:0] captured.
- The config register consumes the strobe and data to drive bank selection, SRAM chip select and RAMDIS.

---
 rtl/cpc_bus_pkg.sv | 15 +
 rtl/cpc_sync.sv | 23 ++
 rtl/cpc_io_wr_capture.sv | 126 ++++++++++++
 tb/tb_cpc_io_wr_capture.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpc_bus_pkg.sv
// Shared types and constants for the CPC Z80 bus capture logic.
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        FIRE     = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    localparam logic [1:0] CFG_SEL_DEFAULT = 2'b11;
    localparam int unsigned CFG_DATA_W     = 6;
    localparam int unsigned GLITCH_CNT_W   = 8;

endpackage

// File: rtl/cpc_sync.sv
// N-flop synchroniser for asynchronous active-low bus strobes; resets to inactive (1).
module cpc_sync #(
    parameter int unsigned N = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[N-2:0], i_d};
        end
    end

    assign o_q = r_chain[N-1];

endmodule

// File: rtl/cpc_io_wr_capture.sv
// Qualifies Z80 I/O write cycles and issues a one-cycle RAM-config strobe with D[5:0].
module cpc_io_wr_capture
    import cpc_bus_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_CYC  = 2,
    parameter logic [1:0]  CFG_SEL     = CFG_SEL_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RESET_B,
    input  logic                    IOREQ_B,
    input  logic                    WR_B,
    input  logic                    M1_B,
    input  logic                    A15,
    input  logic [7:0]              D,
    output logic                    cfg_wr_stb,
    output logic [CFG_DATA_W-1:0]   cfg_data,
    output logic                    io_wr_seen,
    output logic                    busy,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam logic [3:0] FILTER_CNT = 4'(FILTER_CYC);

    logic w_ioreq_s;
    logic w_wr_s;
    logic w_m1_s;
    logic w_io_wr;

    cpc_sync #(.N(SYNC_STAGES)) u_sync_ioreq (
        .i_clk(CLK), .i_rst_n(RESET_B), .i_d(IOREQ_B), .o_q(w_ioreq_s)
    );
    cpc_sync #(.N(SYNC_STAGES)) u_sync_wr (
        .i_clk(CLK), .i_rst_n(RESET_B), .i_d(WR_B), .o_q(w_wr_s)
    );
    cpc_sync #(.N(SYNC_STAGES)) u_sync_m1 (
        .i_clk(CLK), .i_rst_n(RESET_B), .i_d(M1_B), .o_q(w_m1_s)
    );

    // M1 low marks interrupt acknowledge, never treated as a write.
    assign w_io_wr = !w_ioreq_s && !w_wr_s && w_m1_s;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_cnt;
    logic [3:0]              w_next_cnt;
    logic                    w_fire;
    logic                    w_abort;
    logic                    r_stb;
    logic                    r_seen;
    logic [CFG_DATA_W-1:0]   r_data;
    logic [GLITCH_CNT_W-1:0] r_glitch;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_fire       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_io_wr) begin
                    w_next_state = QUAL;
                    w_next_cnt   = 4'd1;
                end
            end
            QUAL: begin
                if (!w_io_wr) begin
                    w_next_state = IDLE;
                    w_abort      = 1'b1;
                end else if (r_cnt == FILTER_CNT) begin
                    w_next_state = FIRE;
                    w_fire       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + 4'd1;
                end
            end
            FIRE: begin
                w_next_state = WAIT_END;
            end
            WAIT_END: begin
                if (!w_io_wr) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Strobes are registered on the QUAL->FIRE edge so they are high for the FIRE cycle.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_stb    <= 1'b0;
            r_seen   <= 1'b0;
            r_data   <= '0;
            r_glitch <= '0;
        end else begin
            r_seen <= w_fire;
            r_stb  <= w_fire && !A15 && (D[7:6] == CFG_SEL);
            if (w_fire && !A15 && (D[7:6] == CFG_SEL)) begin
                r_data <= D[CFG_DATA_W-1:0];
            end
            if (w_abort && (r_glitch != '1)) begin
                r_glitch <= r_glitch + 1'b1;
            end
        end
    end

    assign cfg_wr_stb = r_stb;
    assign io_wr_seen = r_seen;
    assign cfg_data   = r_data;
    assign glitch_cnt = r_glitch;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cpc_io_wr_capture.sv
// Directed bench for cpc_io_wr_capture: table of bus writes plus reset, INTA and glitch sequences.
module tb_cpc_io_wr_capture;

    logic       CLK = 1'b0;
    logic       RESET_B;
    logic       IOREQ_B;
    logic       WR_B;
    logic       M1_B;
    logic       A15;
    logic [7:0] D;
    logic       cfg_wr_stb;
    logic [5:0] cfg_data;
    logic       io_wr_seen;
    logic       busy;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;
    int stb_total = 0;

    cpc_io_wr_capture #(
        .SYNC_STAGES(2),
        .FILTER_CYC(2),
        .CFG_SEL(2'b11)
    ) dut (
        .CLK(CLK),
        .RESET_B(RESET_B),
        .IOREQ_B(IOREQ_B),
        .WR_B(WR_B),
        .M1_B(M1_B),
        .A15(A15),
        .D(D),
        .cfg_wr_stb(cfg_wr_stb),
        .cfg_data(cfg_data),
        .io_wr_seen(io_wr_seen),
        .busy(busy),
        .glitch_cnt(glitch_cnt)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (cfg_wr_stb === 1'b1) stb_total++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       a15;
        logic [7:0] d;
        int         low;
        int         gap;
        int         exp_stb;
        logic [5:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic do_write(input logic a15, input logic [7:0] d, input int low, input int gap,
                            output int stb_n, output int seen_n, output int stb_edge,
                            output int busy_fall);
        stb_n = 0; seen_n = 0; stb_edge = 0; busy_fall = 0;
        @(negedge CLK);
        A15 = a15; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
        for (int e = 1; e <= low; e++) begin
            @(posedge CLK); #1;
            if (cfg_wr_stb) begin
                stb_n++;
                if (stb_edge == 0) stb_edge = e;
            end
            if (io_wr_seen) seen_n++;
        end
        @(negedge CLK);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        for (int e = 1; e <= gap; e++) begin
            @(posedge CLK); #1;
            if (cfg_wr_stb) stb_n++;
            if (io_wr_seen) seen_n++;
            if (!busy && busy_fall == 0) busy_fall = e;
        end
    endtask

    task automatic one_glitch();
        @(negedge CLK); IOREQ_B = 1'b0;
        @(negedge CLK); WR_B = 1'b0;
        @(negedge CLK); WR_B = 1'b1;
        @(negedge CLK); IOREQ_B = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        int stb_n, seen_n, stb_edge, busy_fall, saved;

        vecs[0] = '{1'b0, 8'hC5,  8, 4, 1, 6'h05};
        vecs[1] = '{1'b0, 8'h85,  8, 4, 0, 6'h05};
        vecs[2] = '{1'b1, 8'hC3,  8, 4, 0, 6'h05};
        vecs[3] = '{1'b0, 8'hC1,  8, 2, 1, 6'h01};
        vecs[4] = '{1'b0, 8'hC2,  8, 4, 1, 6'h02};
        vecs[5] = '{1'b0, 8'hC7, 20, 4, 1, 6'h07};

        RESET_B = 1'b0; IOREQ_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; A15 = 1'b0; D = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_stb",    cfg_wr_stb, 0);
        check("reset_seen",   io_wr_seen, 0);
        check("reset_busy",   busy,       0);
        check("reset_data",   cfg_data,   0);
        check("reset_glitch", glitch_cnt, 0);
        @(negedge CLK); RESET_B = 1'b1;
        repeat (2) @(posedge CLK);

        // Reset while the cycle is in QUAL; bus stays low under reset.
        saved = stb_total;
        @(negedge CLK); D = 8'hC5; A15 = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("midqual_busy", busy, 1);
        #2 RESET_B = 1'b0;
        #1;
        check("midqual_rst_busy", busy,       0);
        check("midqual_rst_stb",  cfg_wr_stb, 0);
        check("midqual_rst_seen", io_wr_seen, 0);
        repeat (6) @(posedge CLK);
        @(negedge CLK); IOREQ_B = 1'b1; WR_B = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RESET_B = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check("midqual_no_stb", stb_total, saved);
        check("midqual_data",   cfg_data,  0);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].a15, vecs[i].d, vecs[i].low, vecs[i].gap,
                     stb_n, seen_n, stb_edge, busy_fall);
            check($sformatf("vec%0d_stb_count", i),  stb_n,  vecs[i].exp_stb);
            check($sformatf("vec%0d_seen_count", i), seen_n, 1);
            check($sformatf("vec%0d_cfg_data", i),   cfg_data, vecs[i].exp_data);
            if (vecs[i].exp_stb == 1)
                check($sformatf("vec%0d_stb_edge", i), stb_edge, 5);
            if (vecs[i].gap >= 4)
                check($sformatf("vec%0d_busy_fall_2to3", i),
                      int'(busy_fall >= 2 && busy_fall <= 3), 1);
        end

        // Interrupt acknowledge: IOREQ and M1 low, WR high.
        saved = stb_total;
        seen_n = 0;
        @(negedge CLK); IOREQ_B = 1'b0; M1_B = 1'b0; WR_B = 1'b1; D = 8'hC9;
        for (int e = 0; e < 8; e++) begin
            @(posedge CLK); #1;
            if (io_wr_seen) seen_n++;
        end
        @(negedge CLK); IOREQ_B = 1'b1; M1_B = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("inta_seen",   seen_n,     0);
        check("inta_stb",    stb_total,  saved);
        check("inta_glitch", glitch_cnt, 0);

        saved = stb_total;
        D = 8'hC4;
        one_glitch();
        check("glitch_first", glitch_cnt, 1);
        check("glitch_no_stb", stb_total, saved);
        for (int g = 0; g < 299; g++) one_glitch();
        check("glitch_saturate", glitch_cnt, 255);
        check("glitch_no_stb_many", stb_total, saved);
        check("glitch_data_kept", cfg_data, 6'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
